// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and lock-state encoding,
// used by both the timing generator and the sync receiver.
package vga_timing_pkg;

   localparam int H_PIXELS   = 800;
   localparam int V_LINES    = 521;
   localparam int H_PULSE    = 96;
   localparam int V_PULSE    = 2;
   localparam int H_BP       = 144;
   localparam int H_FP       = 784;
   localparam int V_BP       = 31;
   localparam int V_FP       = 511;
   localparam int LOCK_FRMS  = 2;

   localparam logic [9:0] CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } lock_state_t;

   // Recovered coordinate: counter minus window origin, wrapping mod 1024
   function automatic logic [9:0] coord_of(
      input logic [9:0] cnt,
      input logic [9:0] origin
   );
      return cnt - origin;
   endfunction

endpackage

// File: rtl/vga_sync_edge.sv
// Sync edge detector: optional two-flop synchronizer (VGA_SYNC_RX_INPUT_SYNC_EN)
// followed by a previous-sample register; emits fall/rise pulses.
module vga_sync_edge
   import vga_timing_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic sync_in,
   output logic fall,
   output logic rise
);

   logic sample;
   logic prev_q;
   logic prev_d;

`ifdef VGA_SYNC_RX_INPUT_SYNC_EN
   logic meta_q;
   logic meta_d;
   logic stab_q;
   logic stab_d;

   // Synchronizer stages, idle-high so reset never fakes an edge
   always_comb begin
      meta_d = sync_in;
      stab_d = meta_q;
   end

   // Synchronizer flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b1;
         stab_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         stab_q <= stab_d;
      end
   end

   assign sample = stab_q;
`else
   assign sample = sync_in;
`endif

   // Previous sample follows the (possibly synchronized) input
   always_comb begin
      prev_d = sample;
   end

   // Previous-sample register, idle-high
   always_ff @(posedge clk or posedge rst) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= prev_d;
   end

   assign fall = prev_q & ~sample;
   assign rise = ~prev_q & sample;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: rebuilds h/v counters from hsync/vsync, checks timing,
// locks after clean frames. Optional VGA_SYNC_RX_INPUT_SYNC_EN adds input sync.
module vga_sync_receiver
   import vga_timing_pkg::*;
#(
   parameter int HPIXELS     = H_PIXELS,
   parameter int VLINES      = V_LINES,
   parameter int HPULSE      = H_PULSE,
   parameter int VPULSE      = V_PULSE,
   parameter int HBP         = H_BP,
   parameter int HFP         = H_FP,
   parameter int VBP         = V_BP,
   parameter int VFP         = V_FP,
   parameter int LOCK_FRAMES = LOCK_FRMS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hsync,
   input  logic       vsync,
   output logic [9:0] xCoord,
   output logic [9:0] yCoord,
   output logic       active,
   output logic       locked,
   output logic       syncErr
);

   localparam logic [9:0] LP_H_LAST  = 10'(HPIXELS - 1);
   localparam logic [9:0] LP_HR_LAST = 10'(HPULSE - 1);
   localparam logic [9:0] LP_V_LAST  = 10'(VLINES - 1);
   localparam logic [9:0] LP_VR_LAST = 10'(VPULSE - 1);
   localparam logic [9:0] LP_HBP     = 10'(HBP);
   localparam logic [9:0] LP_HFP     = 10'(HFP);
   localparam logic [9:0] LP_VBP     = 10'(VBP);
   localparam logic [9:0] LP_VFP     = 10'(VFP);
   localparam logic [2:0] LP_LOCK_N  = 3'(LOCK_FRAMES);

   logic hf, hr, vf, vr;

   logic [9:0]  hcnt_q, hcnt_d;
   logic [9:0]  vcnt_q, vcnt_d;
   lock_state_t state_q, state_d;
   logic [2:0]  good_q, good_d;
   logic        frame_err_q, frame_err_d;
   logic        hf_seen_q, hf_seen_d;
   logic        vf_seen_q, vf_seen_d;
   logic        locked_q, locked_d;
   logic        sync_err_q, sync_err_d;
   logic        err;

   vga_sync_edge u_hedge (
      .clk     (clk),
      .rst     (rst),
      .sync_in (hsync),
      .fall    (hf),
      .rise    (hr)
   );

   vga_sync_edge u_vedge (
      .clk     (clk),
      .rst     (rst),
      .sync_in (vsync),
      .fall    (vf),
      .rise    (vr)
   );

   // Counters: hcnt restarts on hsync fall, vcnt steps per line
   always_comb begin
      hcnt_d = hcnt_q;
      vcnt_d = vcnt_q;
      if (hf) hcnt_d = '0;
      else if (hcnt_q != CNT_MAX) hcnt_d = hcnt_q + 10'd1;
      if (hf) begin
         if (vf) vcnt_d = '0;
         else if (vcnt_q != CNT_MAX) vcnt_d = vcnt_q + 10'd1;
      end
   end

   // Timing checks; one OR so coincident violations pulse once
   always_comb begin
      err = 1'b0;
      if (hf && hf_seen_q && hcnt_q != LP_H_LAST) err = 1'b1;
      if (hr && hcnt_q != LP_HR_LAST) err = 1'b1;
      if (vf && !hf) err = 1'b1;
      if (vf && vf_seen_q && vcnt_q != LP_V_LAST) err = 1'b1;
      if (vr && (!hf || vcnt_q != LP_VR_LAST)) err = 1'b1;
      if (!hf && hcnt_q == CNT_MAX - 10'd1) err = 1'b1;
   end

   // Lock FSM next state; leaving LOCKED re-arms the first-edge skips
   always_comb begin
      state_d     = state_q;
      good_d      = good_q;
      frame_err_d = frame_err_q | err;
      hf_seen_d   = hf_seen_q | hf;
      vf_seen_d   = vf_seen_q | vf;
      sync_err_d  = err;
      unique case (state_q)
         SEARCH: begin
            if (vf) begin
               state_d     = VERIFY;
               good_d      = '0;
               frame_err_d = 1'b0;
            end
         end
         VERIFY: begin
            if (vf) begin
               frame_err_d = 1'b0;
               if (frame_err_q || err) begin
                  good_d = '0;
               end else if (good_q + 3'd1 >= LP_LOCK_N) begin
                  good_d  = '0;
                  state_d = LOCKED;
               end else begin
                  good_d = good_q + 3'd1;
               end
            end
         end
         LOCKED: begin
            if (sync_err_q) begin
               state_d   = SEARCH;
               hf_seen_d = 1'b0;
               vf_seen_d = 1'b0;
            end
         end
         default: state_d = SEARCH;
      endcase
      locked_d = (state_d == LOCKED);
   end

   // All receiver state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt_q      <= '0;
         vcnt_q      <= '0;
         state_q     <= SEARCH;
         good_q      <= '0;
         frame_err_q <= 1'b0;
         hf_seen_q   <= 1'b0;
         vf_seen_q   <= 1'b0;
         locked_q    <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         hcnt_q      <= hcnt_d;
         vcnt_q      <= vcnt_d;
         state_q     <= state_d;
         good_q      <= good_d;
         frame_err_q <= frame_err_d;
         hf_seen_q   <= hf_seen_d;
         vf_seen_q   <= vf_seen_d;
         locked_q    <= locked_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign xCoord  = coord_of(hcnt_q, LP_HBP);
   assign yCoord  = coord_of(vcnt_q, LP_VBP);
   assign locked  = locked_q;
   assign syncErr = sync_err_q;
   assign active  = locked_q
                 && hcnt_q >= LP_HBP && hcnt_q < LP_HFP
                 && vcnt_q >= LP_VBP && vcnt_q < LP_VFP;

endmodule

// File: doc/vga_sync_receiver.md
# vga_sync_receiver

Receive-side counterpart of the VGA timing generator. Samples active-low hsync/vsync, rebuilds the horizontal/vertical counters, and checks every line and frame against the nominal 640x480 timing. Reports lock status, recovered pixel coordinates and an active-video flag. Sits at a video input, in loopback test, or as a monitor on the generator's own sync outputs.

## Interface
- HPIXELS, 800: clocks per line
- VLINES, 521: lines per frame
- HPULSE, 96: hsync low width (clocks)
- VPULSE, 2: vsync low width (lines)
- HBP, 144: first active column (counter value)
- HFP, 784: first column after active video
- VBP, 31: first active line
- VFP, 511: first line after active video
- LOCK_FRAMES, 2: consecutive clean frames required to lock (1..7)
- clk  input  1  pixel clock, same as generator
- rst  input  1  reset; one clock; reset is asynchronous and active-high
- hsync  input  1  horizontal sync, active low
- vsync  input  1  vertical sync, active low
- xCoord  output  10  recovered column: hcnt - HBP, mod 1024
- yCoord  output  10  recovered line: vcnt - VBP, mod 1024
- active  output  1  locked and inside the active window
- locked  output  1  timing verified
- syncErr  output  1  one-cycle pulse on any timing violation

## Operation
- Edge detect: the previous sample of each sync resets to 1. HF = hsync fall, HR = hsync rise, VF = vsync fall, VR = vsync rise.
- hcnt (10b):
  - HF -> 0; otherwise +1, saturating at 1023.
  - So hcnt equals the generator's hc one clock later.
- vcnt (10b), updated only on HF:
  - HF with VF in the same cycle -> 0.
  - HF alone -> +1, saturating at 1023.
- Checks. Each failure pulses syncErr and sets a per-frame error flag:
  - HF: hcnt must equal HPIXELS-1 (skipped on the first HF after reset or after SEARCH).
  - HR: hcnt must equal HPULSE-1.
  - VF: must coincide with HF, and vcnt must equal VLINES-1 (skipped on the first VF).
  - VR: must coincide with HF, and vcnt must equal VPULSE-1.
  - hcnt reaching 1023: loss of signal.
- Lock FSM:
  - SEARCH: on first VF -> VERIFY with good=0 and frame flag cleared.
  - VERIFY: at each VF:
    - flag clear -> good+1; when good reaches LOCK_FRAMES -> LOCKED.
    - flag set -> good=0 and stay in VERIFY.
    - Flag clears at every VF.
  - LOCKED: any syncErr -> SEARCH.
  - locked = (state == LOCKED), registered.
- active = locked && HBP <= hcnt < HFP && VBP <= vcnt < VFP.
- Arithmetic: all comparisons are unsigned on 10 bits; coordinate subtraction wraps.

## Timing
- Reset values:
  - hcnt=0, vcnt=0, so xCoord=880 and yCoord=993.
  - active=0, locked=0, syncErr=0, state SEARCH.
- Latency: counters lag the generator by one clock. xCoord==0 one clock after the sync edge input shows generator hc=144.
- syncErr is asserted the clock after the offending sample. On error while LOCKED, locked falls one clock after that.
- Simultaneous events:
  - HF+VF is the normal frame start, with no error.
  - A saturation error coincident with HF is reported once.
- Reset mid-frame returns everything to reset values immediately. Lock must be re-earned.

## Configuration
- VGA_SYNC_RX_INPUT_SYNC_EN:
  - Defined: two-flop synchronizer, reset to 1, on hsync and vsync before edge detect. Total input-to-counter latency is 3 clocks; all counter-relative offsets are unchanged.
  - Undefined: inputs go straight to edge detect, latency 1.

## Structure
- Shared package vga_timing_pkg holds:
  - The default timing constants: 800, 521, 96, 2, 144, 784, 31, 511.
  - The lock-state enum SEARCH/VERIFY/LOCKED.
  - The generator uses the same package.
- One sub-module, vga_sync_edge: optional synchronizer plus previous-sample register, producing fall/rise pulses. Instantiated once for hsync and once for vsync.

## Test plan
- Clean generator drive after rst:
  - locked rises one clock after the 3rd VF.
  - syncErr never pulses.
  - xCoord=0/yCoord=0 one clock after generator hc=144/vc=31.
- While locked, stretch one line to 801 clocks:
  - syncErr pulses at that HF and locked drops.
  - Relock after the 3rd clean VF.
- Hold hsync high for 1100 clocks:
  - syncErr pulses when hcnt hits 1023.
  - FSM goes to SEARCH; active=0.
- Drive vsync low mid-line (hc=400):
  - syncErr pulses, with no vcnt reset on that cycle.
- Assert rst at generator hc=400, vc=200 while locked:
  - Next cycle xCoord=880, yCoord=993, locked=0, active=0.
- Active window while locked:
  - active=1 for generator hc 144..783 on vc 31..510 (shifted one clock), 0 at hc=784 and at vc=511.
